frame_ecc_gen: RTL and testbench
================================

Name: frame_ecc_gen

Overview:
- Per-frame ECC generator: the encoder for the frame ECC check performed by the configuration frame-ECC primitive.
- Streams configuration frame words as they are written toward the fabric.
- Computes the 13-bit check value so the on-chip checker returns SYNDROME = 0 for an unmodified frame.
- Presents the check value, tagged with the frame address, on a valid/ready output.
- Sits between the frame source (readback/scrub buffer or bitstream loader) and the golden-ECC store used by the scrub controller.

Parameters:
- FRAME_WORDS, 101, words per frame. Legal range 2..128; word index fits 7 bits.
- FAR_W, 26, width of the frame address tag.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous, active-high reset.
- FAR_IN  in  FAR_W  frame address; sampled on acceptance of word 0 of a frame.
- DIN  in  32  frame data word.
- DIN_VALID  in  1  DIN and DIN_LAST are valid.
- DIN_LAST  in  1  marks the final word of the frame.
- DIN_READY  out  1  generator can accept a word.
- ECC_OUT  out  13  check value: [12] overall parity, [11:5] word index, [4:0] bit index.
- FAR_OUT  out  FAR_W  address tag of the frame in ECC_OUT.
- LEN_ERR  out  1  frame length mismatch; qualified by ECC_VALID.
- ECC_VALID  out  1  result available.
- ECC_READY  in  1  consumer accepts the result.

Behaviour:
- **States**
  - ACCUM: DIN_READY=1; word counter = index of the next word; counter 0 means idle.
  - HOLD: DIN_READY=0; ECC_VALID=1.
- **Reset** (RST=1 at a CLK edge): state ACCUM, counter 0, accumulator 0. Outputs: ECC_OUT=0, FAR_OUT=0, LEN_ERR=0, ECC_VALID=0, DIN_READY=0 during reset and 1 from the first cycle after. Reset mid-frame or mid-HOLD discards all partial or pending results.
- **Word accept**: a word is accepted when DIN_VALID & DIN_READY. For the accepted word w at index i:
  - acc[4:0] ^= XOR of all bit positions b (0..31) where w[b]=1.
  - acc[11:5] ^= i, only if popcount(w) is odd.
  - acc[12] ^= parity(w).
  - Counter increments.
  - If i = 0, FAR_IN is captured.
- **Frame end**: the frame ends on the accepted word where DIN_LAST=1 or i = FRAME_WORDS-1, whichever comes first.
  - On the next edge: ECC_OUT = final accumulator including that word, FAR_OUT = captured FAR, ECC_VALID=1, state HOLD.
  - Latency: ECC_VALID rises 1 cycle after the last word is accepted.
- **LEN_ERR** = 1 if DIN_LAST=1 at i ≠ FRAME_WORDS-1, or i = FRAME_WORDS-1 with DIN_LAST=0.
  - In the second case the next word starts a new frame.
- **HOLD**
  - ECC_OUT, FAR_OUT and LEN_ERR are stable until ECC_VALID & ECC_READY.
  - On that handshake edge: ECC_VALID=0, accumulator and counter cleared, state ACCUM. DIN_READY=1 in the following cycle.
  - No bypass path: a single result register.
- **Wrap / simultaneous events**
  - Counter never exceeds FRAME_WORDS-1.
  - DIN_VALID while in HOLD is ignored (not accepted).
  - DIN_VALID low mid-frame stalls without altering state.

Optional Feature:
- Macro: FRAME_ECC_GEN_INJECT_EN.
- **Defined**: adds ports INJ_REQ (in 1), INJ_WORD (in 7), INJ_BIT (in 5).
  - INJ_REQ is sampled at the frame's word 0 acceptance and armed for that frame.
  - When the word with index INJ_WORD is accepted, bit INJ_BIT is inverted before accumulation.
  - The armed request is cleared at frame end.
  - Purpose: produce a known-bad golden ECC to exercise the on-chip checker. The resulting syndrome equals {1, INJ_WORD, INJ_BIT}.
- **Undefined**: the ports are absent and no inversion logic exists.

Test Plan:
- All-zero frame (101 words of 0, DIN_LAST on word 100) -> ECC_OUT=13'h0000, LEN_ERR=0, ECC_VALID 1 cycle after the last accept.
- Word 2 = 32'h00000001, others 0, FAR_IN=26'h0123456 -> ECC_OUT=13'h1040, FAR_OUT=26'h0123456.
- Word 100 = 32'h80000000 -> 13'h1C9F. Word 5 = 32'h00000003 alone -> 13'h0001.
- DIN_LAST on word 50 -> ECC_VALID with LEN_ERR=1. The next frame (101 words, correct DIN_LAST) -> LEN_ERR=0 and the accumulator starts from 0.
- ECC_READY held 0 for 10 cycles after ECC_VALID:
  - DIN_READY=0 and outputs stable throughout.
  - On the ready edge ECC_VALID drops and DIN_READY=1 next cycle.
  - RST asserted mid-frame (word 40) -> all outputs 0, next frame computed cleanly.
- With FRAME_ECC_GEN_INJECT_EN: zero frame, INJ_REQ=1, INJ_WORD=7, INJ_BIT=3 -> ECC_OUT=13'h10E3.

Source files
------------

// File: rtl/frame_ecc_gen.sv
// frame_ecc_gen
//   Per-frame ECC encoder for configuration frames. Words are streamed in
//   one at a time. A 13-bit check value is accumulated so that the on-chip
//   frame-ECC checker reports a zero syndrome for an unmodified frame. The
//   check value is presented, tagged with the frame address, on a
//   valid/ready output.
//
//   Check value layout: [12] overall parity, [11:5] word index, [4:0] bit
//   index. Each set data bit at (word i, bit b) contributes {1, i, b} by XOR.
//
// Parameters
//   FRAME_WORDS  words per frame (2..128)
//   FAR_W        width of the frame address tag
//
// Ports
//   CLK        clock
//   RST        synchronous active-high reset
//   FAR_IN     frame address, captured when word 0 is accepted
//   DIN        frame data word
//   DIN_VALID  DIN/DIN_LAST valid
//   DIN_LAST   final word of the frame
//   DIN_READY  generator can accept a word
//   ECC_OUT    check value of the completed frame
//   FAR_OUT    address tag for ECC_OUT
//   LEN_ERR    frame length mismatch (qualified by ECC_VALID)
//   ECC_VALID  result available
//   ECC_READY  consumer accepts the result
//
// Optional feature (macro FRAME_ECC_GEN_INJECT_EN)
//   Adds INJ_REQ / INJ_WORD / INJ_BIT. A request sampled with word 0 arms
//   the frame. The bit INJ_BIT of word INJ_WORD is inverted before
//   accumulation, so a known-bad golden ECC is produced. The checker then
//   reports the syndrome {1, INJ_WORD, INJ_BIT}.

module frame_ecc_gen #(
  parameter int FRAME_WORDS = 101,
  parameter int FAR_W       = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [FAR_W-1:0] FAR_IN,
  input  logic [31:0]      DIN,
  input  logic             DIN_VALID,
  input  logic             DIN_LAST,
  output logic             DIN_READY,
  output logic [12:0]      ECC_OUT,
  output logic [FAR_W-1:0] FAR_OUT,
  output logic             LEN_ERR,
  output logic             ECC_VALID,
  input  logic             ECC_READY
`ifdef FRAME_ECC_GEN_INJECT_EN
  ,
  input  logic             INJ_REQ,
  input  logic [6:0]       INJ_WORD,
  input  logic [4:0]       INJ_BIT
`endif
);

  localparam logic [6:0] LAST_IDX = 7'(FRAME_WORDS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;       // index of the next word; 0 = idle
  logic [12:0]        acc_q, acc_d;
  logic [FAR_W-1:0]   far_q, far_d;       // FAR captured at word 0
  logic [12:0]        ecc_q, ecc_d;       // single result register
  logic [FAR_W-1:0]   far_out_q, far_out_d;
  logic               len_err_q, len_err_d;

  logic               accept;
  logic               is_last_idx;
  logic               frame_end;
  logic [31:0]        word_eff;
  logic               word_par;
  logic [12:0]        contrib;
  logic [12:0]        acc_next;

  // XOR of the positions of all set bits in a word.
  function automatic logic [4:0] bit_index_xor(input logic [31:0] w);
    logic [4:0] x;
    x = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (w[b]) x ^= 5'(b);
    end
    return x;
  endfunction

  // Ready is held low while reset is asserted so nothing can be accepted on
  // the reset edge, and rises in the first cycle after it.
  assign DIN_READY   = (state_q == ACCUM) && !RST;
  assign accept      = DIN_VALID && DIN_READY;
  assign is_last_idx = (cnt_q == LAST_IDX);
  assign frame_end   = DIN_LAST || is_last_idx;

`ifdef FRAME_ECC_GEN_INJECT_EN
  logic       inj_arm_q, inj_arm_d;
  logic [6:0] inj_word_q, inj_word_d;
  logic [4:0] inj_bit_q, inj_bit_d;
  logic       inj_arm_eff;
  logic [6:0] inj_word_eff;
  logic [4:0] inj_bit_eff;

  always_comb begin
    // Word 0 must see the request in the same cycle it is sampled, so the
    // live inputs are used until the captured copy takes over.
    inj_arm_eff  = (cnt_q == '0) ? INJ_REQ  : inj_arm_q;
    inj_word_eff = (cnt_q == '0) ? INJ_WORD : inj_word_q;
    inj_bit_eff  = (cnt_q == '0) ? INJ_BIT  : inj_bit_q;

    word_eff = DIN;
    if (inj_arm_eff && (cnt_q == inj_word_eff)) begin
      word_eff[inj_bit_eff] = ~DIN[inj_bit_eff];
    end

    inj_arm_d  = inj_arm_q;
    inj_word_d = inj_word_q;
    inj_bit_d  = inj_bit_q;
    if (accept) begin
      if (cnt_q == '0) begin
        inj_arm_d  = INJ_REQ;
        inj_word_d = INJ_WORD;
        inj_bit_d  = INJ_BIT;
      end
      if (frame_end) inj_arm_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_arm_q  <= 1'b0;
      inj_word_q <= '0;
      inj_bit_q  <= '0;
    end else begin
      inj_arm_q  <= inj_arm_d;
      inj_word_q <= inj_word_d;
      inj_bit_q  <= inj_bit_d;
    end
  end
`else
  always_comb begin
    word_eff = DIN;
  end
`endif

  // Contribution of the current word: parity, the word index (when an odd
  // number of bits is set), and the XOR of set bit positions.
  always_comb begin
    word_par = ^word_eff;
    contrib  = {word_par, (word_par ? cnt_q : 7'd0), bit_index_xor(word_eff)};
    acc_next = acc_q ^ contrib;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    far_d     = far_q;
    ecc_d     = ecc_q;
    far_out_d = far_out_q;
    len_err_d = len_err_q;

    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == '0) far_d = FAR_IN;
          if (frame_end) begin
            ecc_d     = acc_next;
            far_out_d = (cnt_q == '0) ? FAR_IN : far_q;
            // Mismatch when DIN_LAST and the last index disagree.
            len_err_d = DIN_LAST ^ is_last_idx;
            // The accumulator is cleared as the result is latched. This is
            // equivalent to clearing it on the output handshake because
            // nothing is accepted while the result is held.
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = HOLD;
          end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      HOLD: begin
        if (ECC_READY) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      acc_q     <= '0;
      far_q     <= '0;
      ecc_q     <= '0;
      far_out_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      far_q     <= far_d;
      ecc_q     <= ecc_d;
      far_out_q <= far_out_d;
      len_err_q <= len_err_d;
    end
  end

  assign ECC_OUT   = ecc_q;
  assign FAR_OUT   = far_out_q;
  assign LEN_ERR   = len_err_q;
  assign ECC_VALID = (state_q == HOLD);

endmodule

// File: tb/tb_frame_ecc_gen.sv
// Self-checking bench for frame_ecc_gen. The reference treats the check
// value as the XOR over every set data bit of the code {1, word, bit}.
module tb_frame_ecc_gen;

  localparam int FW    = 101;
  localparam int FAR_W = 26;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [FAR_W-1:0] FAR_IN = '0;
  logic [31:0]      DIN = '0;
  logic             DIN_VALID = 1'b0;
  logic             DIN_LAST = 1'b0;
  logic             DIN_READY;
  logic [12:0]      ECC_OUT;
  logic [FAR_W-1:0] FAR_OUT;
  logic             LEN_ERR;
  logic             ECC_VALID;
  logic             ECC_READY = 1'b0;
`ifdef FRAME_ECC_GEN_INJECT_EN
  logic             INJ_REQ = 1'b0;
  logic [6:0]       INJ_WORD = '0;
  logic [4:0]       INJ_BIT = '0;
`endif

  logic [31:0] words [0:127];
  int checks = 0;
  int errors = 0;

  frame_ecc_gen #(.FRAME_WORDS(FW), .FAR_W(FAR_W)) dut (
    .CLK(CLK), .RST(RST), .FAR_IN(FAR_IN), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_LAST(DIN_LAST), .DIN_READY(DIN_READY), .ECC_OUT(ECC_OUT),
    .FAR_OUT(FAR_OUT), .LEN_ERR(LEN_ERR), .ECC_VALID(ECC_VALID),
    .ECC_READY(ECC_READY)
`ifdef FRAME_ECC_GEN_INJECT_EN
    , .INJ_REQ(INJ_REQ), .INJ_WORD(INJ_WORD), .INJ_BIT(INJ_BIT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  function automatic logic [12:0] model_ecc(input int n, input bit inj, input int iw, input int ib);
    logic [12:0] r;
    logic [31:0] w;
    r = '0;
    for (int i = 0; i < n; i++) begin
      w = words[i];
      if (inj && i == iw) w[ib] = ~w[ib];
      for (int b = 0; b < 32; b++) if (w[b]) r ^= {1'b1, 7'(i), 5'(b)};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  task automatic clear_words();
    for (int i = 0; i < 128; i++) words[i] = '0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) words[i] = rand_word();
  endtask

  // Streams words[0..n-1]; called at a negedge, returns at the negedge right
  // after the last accept edge with the outputs sampled there.
  task automatic run_frame(input int n, input bit last_flag, input logic [FAR_W-1:0] far,
                           input bit stalls, output logic [12:0] ecc,
                           output logic [FAR_W-1:0] fo, output logic le,
                           output logic got, output logic early);
    early = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          DIN_VALID = 1'b0;
          DIN       = $urandom;
          DIN_LAST  = 1'($urandom);
          FAR_IN    = FAR_W'($urandom);
          @(negedge CLK);
        end
      end
      DIN       = words[i];
      DIN_VALID = 1'b1;
      DIN_LAST  = last_flag && (i == n - 1);
      FAR_IN    = (i == 0) ? far : FAR_W'($urandom);
      if (ECC_VALID) early = 1'b1;
      @(negedge CLK);
    end
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    got = ECC_VALID;
    ecc = ECC_OUT;
    fo  = FAR_OUT;
    le  = LEN_ERR;
  endtask

  task automatic consume();
    ECC_READY = 1'b1;
    @(negedge CLK);
    ECC_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ECC_OUT, FAR_OUT, LEN_ERR, ECC_VALID, DIN_READY} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ecc=%h far=%h len=%b vld=%b rdy=%b, expected all 0",
               ECC_OUT, FAR_OUT, LEN_ERR, ECC_VALID, DIN_READY);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (DIN_READY !== 1'b1 || ECC_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", DIN_READY, ECC_VALID);
    end
  endtask

  task automatic test_directed();
    logic [12:0] ecc;
    logic [FAR_W-1:0] fo;
    logic le, got, early;
    int          idx [4] = '{0, 2, 100, 5};
    logic [31:0] val [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'h3};
    logic [12:0] exp [4] = '{13'h0000, 13'h1040, 13'h1C9F, 13'h0001};
    for (int k = 0; k < 4; k++) begin
      clear_words();
      words[idx[k]] = val[k];
      run_frame(FW, 1'b1, 26'h0123456, 1'b0, ecc, fo, le, got, early);
      checks++;
      if (got !== 1'b1 || early !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_latency: got valid=%b early=%b, expected valid=1 early=0", k, got, early);
      end
      checks++;
      if (ecc !== exp[k] || le !== 1'b0 || fo !== 26'h0123456) begin
        errors++;
        $display("FAIL directed%0d_result: got ecc=%h len=%b far=%h, expected ecc=%h len=0 far=0123456",
                 k, ecc, le, fo, exp[k]);
      end
      consume();
      checks++;
      if (ECC_VALID !== 1'b0 || DIN_READY !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_handshake: got vld=%b rdy=%b, expected vld=0 rdy=1", k, ECC_VALID, DIN_READY);
      end
    end
  endtask

  task automatic test_length();
    logic [12:0] ecc;
    logic [FAR_W-1:0] fo, far;
    logic le, got, early;
    // Early DIN_LAST on word 50.
    fill_random();
    far = FAR_W'($urandom);
    run_frame(51, 1'b1, far, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || le !== 1'b1 || ecc !== model_ecc(51, 0, 0, 0) || fo !== far) begin
      errors++;
      $display("FAIL short_frame: got vld=%b len=%b ecc=%h far=%h, expected vld=1 len=1 ecc=%h far=%h",
               got, le, ecc, fo, model_ecc(51, 0, 0, 0), far);
    end
    consume();
    // Next full frame must start from a clean accumulator.
    fill_random();
    run_frame(FW, 1'b1, far, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || le !== 1'b0 || ecc !== model_ecc(FW, 0, 0, 0)) begin
      errors++;
      $display("FAIL after_short: got vld=%b len=%b ecc=%h, expected vld=1 len=0 ecc=%h",
               got, le, ecc, model_ecc(FW, 0, 0, 0));
    end
    consume();
    // Missing DIN_LAST: frame still ends at the last index.
    fill_random();
    run_frame(FW, 1'b0, far, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || le !== 1'b1 || ecc !== model_ecc(FW, 0, 0, 0)) begin
      errors++;
      $display("FAIL missing_last: got vld=%b len=%b ecc=%h, expected vld=1 len=1 ecc=%h",
               got, le, ecc, model_ecc(FW, 0, 0, 0));
    end
    consume();
    // Minimum two-word frame right after.
    fill_random();
    run_frame(2, 1'b1, far, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || le !== 1'b1 || ecc !== model_ecc(2, 0, 0, 0)) begin
      errors++;
      $display("FAIL two_word: got vld=%b len=%b ecc=%h, expected vld=1 len=1 ecc=%h",
               got, le, ecc, model_ecc(2, 0, 0, 0));
    end
    consume();
  endtask

  task automatic test_hold_stall();
    logic [12:0] ecc;
    logic [FAR_W-1:0] fo, far;
    logic le, got, early;
    int bad;
    fill_random();
    far = FAR_W'($urandom);
    run_frame(FW, 1'b1, far, 1'b0, ecc, fo, le, got, early);
    bad = 0;
    // Offered words during HOLD must be ignored.
    for (int c = 0; c < 10; c++) begin
      DIN = $urandom; DIN_VALID = 1'b1; DIN_LAST = 1'($urandom);
      @(negedge CLK);
      checks++;
      if (DIN_READY !== 1'b0 || ECC_VALID !== 1'b1 || ECC_OUT !== ecc || FAR_OUT !== fo || LEN_ERR !== le) begin
        errors++; bad++;
        if (bad < 4)
          $display("FAIL hold_stable c%0d: got rdy=%b vld=%b ecc=%h, expected rdy=0 vld=1 ecc=%h",
                   c, DIN_READY, ECC_VALID, ECC_OUT, ecc);
      end
    end
    DIN_VALID = 1'b0;
    DIN_LAST  = 1'b0;
    checks++;
    if (ecc !== model_ecc(FW, 0, 0, 0)) begin
      errors++;
      $display("FAIL hold_value: got %h expected %h", ecc, model_ecc(FW, 0, 0, 0));
    end
    consume();
    checks++;
    if (ECC_VALID !== 1'b0 || DIN_READY !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got vld=%b rdy=%b, expected vld=0 rdy=1", ECC_VALID, DIN_READY);
    end
    fill_random();
    run_frame(FW, 1'b1, far, 1'b1, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || ecc !== model_ecc(FW, 0, 0, 0) || le !== 1'b0) begin
      errors++;
      $display("FAIL after_hold: got vld=%b ecc=%h len=%b, expected vld=1 ecc=%h len=0",
               got, ecc, le, model_ecc(FW, 0, 0, 0));
    end
    consume();
  endtask

  task automatic test_reset_midframe();
    logic [12:0] ecc;
    logic [FAR_W-1:0] fo, far;
    logic le, got, early;
    // Leave a non-zero result in the output register first.
    clear_words();
    words[3] = 32'h0000_0010;
    far = 26'h3ABCDEF;
    run_frame(FW, 1'b0, far, 1'b0, ecc, fo, le, got, early);
    consume();
    fill_random();
    for (int i = 0; i < 40; i++) begin
      DIN = words[i]; DIN_VALID = 1'b1; DIN_LAST = 1'b0; FAR_IN = FAR_W'($urandom);
      @(negedge CLK);
    end
    DIN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({ECC_OUT, FAR_OUT, LEN_ERR, ECC_VALID, DIN_READY} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got ecc=%h far=%h len=%b vld=%b rdy=%b, expected all 0",
               ECC_OUT, FAR_OUT, LEN_ERR, ECC_VALID, DIN_READY);
    end
    RST = 1'b0;
    @(negedge CLK);
    fill_random();
    far = FAR_W'($urandom);
    run_frame(FW, 1'b1, far, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (got !== 1'b1 || ecc !== model_ecc(FW, 0, 0, 0) || le !== 1'b0 || fo !== far) begin
      errors++;
      $display("FAIL after_reset: got vld=%b ecc=%h len=%b far=%h, expected vld=1 ecc=%h len=0 far=%h",
               got, ecc, le, fo, model_ecc(FW, 0, 0, 0), far);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [12:0] ecc, exp;
    logic [FAR_W-1:0] fo, far;
    logic le, got, early, last_flag, exp_le;
    int n;
    for (int f = 0; f < 14; f++) begin
      fill_random();
      n = $urandom_range(2, FW);
      last_flag = (n < FW) ? 1'b1 : 1'($urandom);
      exp_le = last_flag ? (n != FW) : 1'b1;
      far = FAR_W'($urandom);
      exp = model_ecc(n, 0, 0, 0);
      run_frame(n, last_flag, far, 1'($urandom), ecc, fo, le, got, early);
      checks++;
      if (got !== 1'b1 || early !== 1'b0 || ecc !== exp || le !== exp_le || fo !== far) begin
        errors++;
        $display("FAIL random%0d n=%0d: got vld=%b ecc=%h len=%b far=%h, expected vld=1 ecc=%h len=%b far=%h",
                 f, n, got, ecc, le, fo, exp, exp_le, far);
      end
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      consume();
    end
  endtask

`ifdef FRAME_ECC_GEN_INJECT_EN
  task automatic test_inject();
    logic [12:0] ecc;
    logic [FAR_W-1:0] fo;
    logic le, got, early;
    clear_words();
    INJ_REQ = 1'b1; INJ_WORD = 7'd7; INJ_BIT = 5'd3;
    run_frame(FW, 1'b1, 26'h1, 1'b0, ecc, fo, le, got, early);
    INJ_REQ = 1'b0;
    checks++;
    if (got !== 1'b1 || ecc !== 13'h10E3) begin
      errors++;
      $display("FAIL inject_zero: got vld=%b ecc=%h, expected vld=1 ecc=10e3", got, ecc);
    end
    consume();
    fill_random();
    run_frame(FW, 1'b1, 26'h2, 1'b0, ecc, fo, le, got, early);
    checks++;
    if (ecc !== model_ecc(FW, 0, 0, 0)) begin
      errors++;
      $display("FAIL inject_cleared: got %h expected %h", ecc, model_ecc(FW, 0, 0, 0));
    end
    consume();
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset();
    test_directed();
    test_length();
    test_hold_stall();
    test_reset_midframe();
    test_back_to_back();
`ifdef FRAME_ECC_GEN_INJECT_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
